bcd_score_counter: RTL and testbench
====================================

# bcd_score_counter

Parametrised, fully synchronous decimal score counter for the game datapath. It replaces the ripple-clocked per-digit chain with a single-clock BCD adder. It adds a run/pause control, bonus increments, saturation and a high-score register. It sits between the game FSM (run, clear, bonus events) and the seven-segment display bank.

## Interface
- DIGITS, 6: number of BCD digits; legal range 1..8.
- TICK_DIV, 50000000: clk cycles per time tick; legal minimum 2.
- clk  in  1  system clock; every register is clocked by clk only.
- reset  in  1  synchronous, active-low reset.
- run  in  1  1 = divider advances and time ticks score; 0 = paused, divider frozen.
- clear  in  1  synchronous clear of score and divider; high score kept.
- add_valid  in  1  one-cycle bonus request.
- add_bcd  in  4  bonus amount added to the units digit; values 10..15 are treated as 9.
- show_hi  in  1  display select: 0 = score, 1 = high score.
- score_bcd  out  4*DIGITS  current score, packed BCD, digit 0 in LSBs.
- hiscore_bcd  out  4*DIGITS  high score, packed BCD.
- seg  out  7*DIGITS  active-low segments of the selected value; digit i in seg[7i+6:7i].
- tick  out  1  one-cycle pulse when a time tick is applied.
- sat  out  1  high while score equals all nines.

## Operation
- Divider: counter div, range 0..TICK_DIV-1.
  - With run=1: div increments each cycle. When div==TICK_DIV-1, div returns to 0 and a tick occurs that cycle.
  - With run=0: div holds and no tick occurs.
- Increment per cycle: inc = (add_valid ? min(add_bcd,9) : 0) + (tick ? 1 : 0), range 0..10.
  - inc is added to score in one cycle with a decimal carry chain.
  - Each digit result ≥10 subtracts 10 and carries into the next digit.
- Saturation:
  - If the sum exceeds 10^DIGITS-1, score loads all nines; there is no wrap-around.
  - Once saturated, further ticks and bonuses are absorbed; sat=1.
- Clear: score←0 and div←0; same-cycle tick and add are discarded. High score is unchanged.
- High score: registered. When score > hiscore (decimal magnitude compare, MSD first), hiscore←score on the next edge. Reset is the only thing that clears hiscore.
- Display: seg is combinational from the show_hi mux and per-digit hex decode.
  - Segment patterns 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
  - Non-BCD nibbles (unreachable) show 1111111.
- Every score digit is always in 0..9.

## Timing
- Reset (reset=0 at a clk edge): score_bcd=0, hiscore_bcd=0, div=0, tick=0, sat=0. seg then shows all digits "0" (1000000 each).
- Reset mid-operation overrides clear, run and add_valid in the same cycle.
- Priority: reset > clear > (tick + add).
- tick is registered: it is asserted in the cycle after the edge where div wrapped, coincident with score_bcd showing the incremented value.
- Latency: add_valid sampled at edge N → score_bcd updated after edge N (visible cycle N+1). hiscore follows one cycle later (N+2).
- Tick and add in the same cycle: both applied, total inc up to 10.
- Pausing (run 1→0) keeps div; resuming continues from the held count, so no tick is lost or duplicated.
- sat is combinational from score_bcd.

## Test plan
- Reset, DIGITS=3, TICK_DIV=4, run=1, 20 cycles → tick every 4th cycle; score_bcd 0x000→0x005; hiscore tracks one cycle behind.
- Score 0x099, add_valid with add_bcd=7 in the cycle of a tick → score 0x107 next cycle (carry through two digits).
- Score 0x995, add_bcd=9 → score 0x999, sat=1. A further tick leaves 0x999.
- Score 0x042, hiscore 0x042; pulse clear, then run 8 cycles → score 0x002, hiscore stays 0x042. With show_hi=1, seg digit 0 = 0100100, digit 1 = 0011001, digit 2 = 1000000.
- run=0 with div=2 for 10 cycles → no tick, score constant. With run=1, the first tick arrives 2 cycles later.
- add_bcd=15 → treated as 9. Assert reset together with add_valid and clear mid-count → all outputs return to their reset values.

Source files
------------

// File: rtl/bcd_score_counter_if.sv
// Bundle between the game FSM (master) and the BCD score counter (slave).
//   run         master->slave  1 = time base advances, 0 = paused
//   clear       master->slave  synchronous clear of score and divider
//   add_valid   master->slave  one-cycle bonus request
//   add_bcd     master->slave  bonus amount (10..15 treated as 9)
//   show_hi     master->slave  display select: 0 = score, 1 = high score
//   score_bcd   slave->master  packed BCD score, digit 0 in LSBs
//   hiscore_bcd slave->master  packed BCD high score
//   seg         slave->master  active-low segments, digit i in seg[7i+6:7i]
//   tick        slave->master  one-cycle pulse when a time tick is applied
//   sat         slave->master  score is all nines
interface bcd_score_counter_if #(
    parameter int unsigned DIGITS = 6
);
    logic                  run;
    logic                  clear;
    logic                  add_valid;
    logic [3:0]            add_bcd;
    logic                  show_hi;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   hiscore_bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  tick;
    logic                  sat;

    modport master (
        output run, clear, add_valid, add_bcd, show_hi,
        input  score_bcd, hiscore_bcd, seg, tick, sat
    );

    modport slave (
        input  run, clear, add_valid, add_bcd, show_hi,
        output score_bcd, hiscore_bcd, seg, tick, sat
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Single-clock decimal score counter with time-base divider, bonus adds,
// saturation at all nines, a high-score register and seven-segment decode.
//   clk    system clock, the only clock
//   reset  synchronous, active-low reset
//   bus    bcd_score_counter_if.slave: run/clear/add controls in,
//          score, high score, segments, tick and sat out
module bcd_score_counter #(
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned TICK_DIV = 50000000
) (
    input logic                 clk,
    input logic                 reset,
    bcd_score_counter_if.slave  bus
);
    localparam int unsigned DivW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

    logic [DivW-1:0]     div_q;
    logic [4*DIGITS-1:0] score_q;
    logic [4*DIGITS-1:0] hiscore_q;
    logic                tick_q;

    logic                wrap;
    logic [3:0]          bonus;
    logic [3:0]          inc;
    logic [4*DIGITS-1:0] sum_bcd;
    logic [4*DIGITS-1:0] score_d;
    logic                carry;
    logic [4:0]          digit_sum;
    logic [4:0]          digit_adj;

    // Divider wrap is the tick event; the registered tick_q lines up with the
    // score that already includes it.
    always_comb begin
        wrap  = bus.run && (div_q == DivMax);
        bonus = 4'd0;
        if (bus.add_valid) begin
            bonus = (bus.add_bcd > 4'd9) ? 4'd9 : bus.add_bcd;
        end
        inc = bonus + {3'b000, wrap};
    end

    // Decimal ripple add of inc (0..10) into the units digit. Digit 0 can reach
    // 19, every other digit at most 10, so a single carry bit always suffices.
    always_comb begin
        sum_bcd   = '0;
        carry     = 1'b0;
        digit_sum = '0;
        digit_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, score_q[4*i +: 4]} + {4'b0000, carry};
            if (i == 0) begin
                digit_sum = digit_sum + {1'b0, inc};
            end
            digit_adj = digit_sum - 5'd10;
            if (digit_sum >= 5'd10) begin
                sum_bcd[4*i +: 4] = digit_adj[3:0];
                carry             = 1'b1;
            end else begin
                sum_bcd[4*i +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        // Carry out of the top digit means the value left the range: clamp.
        score_d = carry ? AllNines : sum_bcd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q     <= '0;
            score_q   <= '0;
            hiscore_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            // Packed BCD orders the same as its decimal value, so an unsigned
            // compare is an MSD-first magnitude compare.
            if (score_q > hiscore_q) begin
                hiscore_q <= score_q;
            end
            if (bus.clear) begin
                div_q   <= '0;
                score_q <= '0;
                tick_q  <= 1'b0;
            end else begin
                if (bus.run) begin
                    div_q <= wrap ? '0 : div_q + DivW'(1);
                end
                score_q <= score_d;
                tick_q  <= wrap;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] disp_bcd;
    logic [7*DIGITS-1:0] seg_all;

    always_comb begin
        disp_bcd = bus.show_hi ? hiscore_q : score_q;
        seg_all  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_all[7*i +: 7] = seg_decode(disp_bcd[4*i +: 4]);
        end
    end

    assign bus.score_bcd   = score_q;
    assign bus.hiscore_bcd = hiscore_q;
    assign bus.seg         = seg_all;
    assign bus.tick        = tick_q;
    assign bus.sat         = (score_q == AllNines);
endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter with DIGITS=3, TICK_DIV=4.
module tb_bcd_score_counter;
    localparam int unsigned Digits  = 3;
    localparam int unsigned TickDiv = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;

    logic clk;
    logic reset;

    int n_vec;
    int n_miss;

    bcd_score_counter_if #(.DIGITS(Digits)) bus ();

    bcd_score_counter #(
        .DIGITS   (Digits),
        .TICK_DIV (TickDiv)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_amt(input logic [3:0] a);
        bus.add_valid = 1'b1;
        bus.add_bcd   = a;
        step();
        bus.add_valid = 1'b0;
        bus.add_bcd   = 4'd0;
    endtask

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        reset         = 1'b0;
        bus.run       = 1'b0;
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_bcd   = 4'd0;
        bus.show_hi   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_score", bus.score_bcd, 64'h000);
        check("rst_hi", bus.hiscore_bcd, 64'h000);
        check("rst_tick", bus.tick, 64'd0);
        check("rst_sat", bus.sat, 64'd0);
        check("rst_seg", bus.seg, {S0, S0, S0});

        // Free run: tick every 4th cycle, hiscore one cycle behind
        reset   = 1'b1;
        bus.run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("run_tick", bus.tick, 64'((i % 4) == 0));
            check("run_score", bus.score_bcd, 64'(i / 4));
            check("run_hi", bus.hiscore_bcd, 64'((i - 1) / 4));
        end
        bus.run = 1'b0;

        // Build score to 42 with bonuses: 5 + 4*9 + 1
        repeat (4) add_amt(4'd9);
        add_amt(4'd1);
        step();
        check("b42_score", bus.score_bcd, 64'h042);
        check("b42_hi", bus.hiscore_bcd, 64'h042);

        // Clear with a concurrent bonus: bonus discarded, hiscore kept
        bus.clear     = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_bcd   = 4'd3;
        step();
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_bcd   = 4'd0;
        check("clr_score", bus.score_bcd, 64'h000);
        check("clr_hi", bus.hiscore_bcd, 64'h042);
        check("clr_tick", bus.tick, 64'd0);

        bus.run = 1'b1;
        repeat (8) step();
        bus.run = 1'b0;
        check("clr8_score", bus.score_bcd, 64'h002);
        check("clr8_hi", bus.hiscore_bcd, 64'h042);
        bus.show_hi = 1'b1;
        #1;
        check("seg_hi", bus.seg, {S0, S4, S2});
        bus.show_hi = 1'b0;
        #1;
        check("seg_score", bus.seg, {S0, S0, S2});

        // Pause with div=2: no tick while paused, resume ticks after 2 cycles
        bus.run = 1'b1;
        step();
        step();
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_tick", bus.tick, 64'd0);
        end
        check("pause_score", bus.score_bcd, 64'h002);
        bus.run = 1'b1;
        step();
        check("resume_t1", bus.tick, 64'd0);
        step();
        check("resume_t2", bus.tick, 64'd1);
        check("resume_score", bus.score_bcd, 64'h003);
        bus.run = 1'b0;

        // Carry through two digits: 99 + 7 + tick = 107
        repeat (10) add_amt(4'd9);
        add_amt(4'd6);
        check("b99_score", bus.score_bcd, 64'h099);
        bus.run = 1'b1;
        repeat (3) step();
        check("pre_tick", bus.tick, 64'd0);
        bus.add_valid = 1'b1;
        bus.add_bcd   = 4'd7;
        step();
        bus.add_valid = 1'b0;
        bus.add_bcd   = 4'd0;
        bus.run       = 1'b0;
        check("carry_score", bus.score_bcd, 64'h107);
        check("carry_tick", bus.tick, 64'd1);
        check("carry_sat", bus.sat, 64'd0);

        // add_bcd = 15 clamps to 9
        add_amt(4'd15);
        check("clamp15", bus.score_bcd, 64'h116);

        // Saturation: 116 + 97*9 = 989, +6 = 995, +9 saturates
        repeat (97) add_amt(4'd9);
        check("b989_score", bus.score_bcd, 64'h989);
        add_amt(4'd6);
        check("b995_score", bus.score_bcd, 64'h995);
        check("b995_sat", bus.sat, 64'd0);
        add_amt(4'd9);
        check("sat_score", bus.score_bcd, 64'h999);
        check("sat_flag", bus.sat, 64'd1);
        bus.run = 1'b1;
        repeat (4) step();
        bus.run = 1'b0;
        check("sat_tick", bus.tick, 64'd1);
        check("sat_tick_score", bus.score_bcd, 64'h999);
        add_amt(4'd5);
        check("sat_add_score", bus.score_bcd, 64'h999);
        step();
        check("sat_hi", bus.hiscore_bcd, 64'h999);

        // Reset mid-count overrides clear, run and add_valid
        bus.run = 1'b1;
        step();
        step();
        reset         = 1'b0;
        bus.clear     = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_bcd   = 4'd5;
        bus.show_hi   = 1'b1;
        step();
        check("mrst_score", bus.score_bcd, 64'h000);
        check("mrst_hi", bus.hiscore_bcd, 64'h000);
        check("mrst_tick", bus.tick, 64'd0);
        check("mrst_sat", bus.sat, 64'd0);
        check("mrst_seg", bus.seg, {S0, S0, S0});
        reset         = 1'b1;
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_bcd   = 4'd0;
        bus.show_hi   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("post_rst_tick", bus.tick, 64'(i == 4));
        end
        check("post_rst_score", bus.score_bcd, 64'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
